store_rmw_unit: RTL

- Downstream of the store memory encoder: takes the encoder's lane-positioned 32-bit store data and 32-bit bit mask plus the store address.
- Commits the store to a word-wide data memory that has no byte enables.
- Partial-word stores use read-modify-write; full-word stores write directly.
- Back-pressures the pipeline with a valid/ready handshake and pulses store-complete to the control logic.

---
 rtl/store_rmw_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/store_rmw_unit.sv
// Commits lane-positioned stores to a word-wide memory without byte enables.
// Partial-word stores are merged by read-modify-write; full words are written directly.
module store_rmw_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [31:0]           in_data,
  input  logic [31:0]           in_mask,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           mask_q, mask_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  unused_addr_lo;

  assign unused_addr_lo = ^in_addr[1:0];
  assign accept         = in_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = in_addr[ADDR_WIDTH-1:2];
          // Masking here scrubs undefined lanes before they reach any register.
          data_d = in_data & in_mask;
          mask_d = in_mask;
          if (in_mask == 32'hffff_ffff) begin
            wdata_d = in_data & in_mask;
            state_d = WR_REQ;
          end else if (in_mask == 32'h0) begin
            done_d = 1'b1;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (mem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          wdata_d = (mem_rdata & ~mask_q) | (data_q & mask_q);
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_we    = (state_q == WR_REQ);
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign done      = done_q;

endmodule
